float_adder_arbiter: RTL and testbench

Round-robin controller that shares one single-precision float adder instance (`clk`, `rst`, `a`, `b`, `ip_ready`, `sum`, `valid` contract) among `NREQ` requesters in the activation-function datapath. It accepts one operand pair at a time, drives the adder's `ip_ready` handshake until `valid`, and returns the sum tagged with the requester index. It then drains the adder back to idle before issuing the next operation. A cycle-count watchdog bounds every wait on the adder.

---
 rtl/float_adder_arbiter.sv | 144 ++++++++++++++
 tb/tb_float_adder_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_arbiter.sv
// Round-robin arbiter sharing one float adder among NREQ requesters.
// Three-state controller (IDLE/WAIT/DRAIN) with a watchdog on every adder wait.
module float_adder_arbiter #(
   parameter int unsigned DWIDTH  = 32,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = $clog2(NREQ),
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DWIDTH-1:0]   req_a,
   input  logic [NREQ*DWIDTH-1:0]   req_b,
   output logic [NREQ-1:0]          req_ready,
   output logic                     resp_valid,
   output logic [IDW-1:0]           resp_id,
   output logic [DWIDTH-1:0]        resp_sum,
   output logic                     resp_err,
   output logic [DWIDTH-1:0]        add_a,
   output logic [DWIDTH-1:0]        add_b,
   output logic                     add_ip_ready,
   input  logic [DWIDTH-1:0]        add_sum,
   input  logic                     add_valid,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;

   state_t            state, state_nxt;
   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    id_q;
   logic [IDW-1:0]    grant;
   logic [IDW-1:0]    scan_idx;
   logic              grant_found;
   logic              accept;
   logic [CW-1:0]     wd_cnt;
   logic              wd_hit;
   logic [DWIDTH-1:0] a_arr [NREQ];
   logic [DWIDTH-1:0] b_arr [NREQ];

   always_comb begin
      for (int unsigned k = 0; k < NREQ; k++) begin
         a_arr[k] = req_a[k*DWIDTH +: DWIDTH];
         b_arr[k] = req_b[k*DWIDTH +: DWIDTH];
      end
   end

   // Scan from ptr upward; IDW-bit addition wraps modulo NREQ.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      scan_idx    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = ptr + IDW'(k);
         if (!grant_found && req_valid[scan_idx]) begin
            grant       = scan_idx;
            grant_found = 1'b1;
         end
      end
   end

   assign accept = (state == ST_IDLE) && grant_found;
   assign wd_hit = (wd_cnt == CW'(TIMEOUT - 1));
   assign busy   = (state != ST_IDLE);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept)                state_nxt = ST_WAIT;
         ST_WAIT:  if (add_valid || wd_hit)   state_nxt = ST_DRAIN;
         ST_DRAIN: if (!add_valid || wd_hit)  state_nxt = ST_IDLE;
         default:                             state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         id_q         <= '0;
         wd_cnt       <= '0;
         add_a        <= '0;
         add_b        <= '0;
         add_ip_ready <= 1'b0;
         resp_valid   <= 1'b0;
         resp_id      <= '0;
         resp_sum     <= '0;
         resp_err     <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         resp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  add_a        <= a_arr[grant];
                  add_b        <= b_arr[grant];
                  id_q         <= grant;
                  ptr          <= grant + IDW'(1);
                  wd_cnt       <= '0;
                  add_ip_ready <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (add_valid) begin
                  resp_valid   <= 1'b1;
                  resp_sum     <= add_sum;
                  resp_id      <= id_q;
                  resp_err     <= 1'b0;
                  add_ip_ready <= 1'b0;
                  wd_cnt       <= '0;
               end else if (wd_hit) begin
                  resp_valid   <= 1'b1;
                  resp_sum     <= '0;
                  resp_id      <= id_q;
                  resp_err     <= 1'b1;
                  timeout_err  <= 1'b1;
                  add_ip_ready <= 1'b0;
                  wd_cnt       <= '0;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            ST_DRAIN: begin
               // A stuck-high valid is abandoned silently; only the sticky flag records it.
               if (add_valid) begin
                  if (wd_hit) timeout_err <= 1'b1;
                  else        wd_cnt      <= wd_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_adder_arbiter.sv
// Self-checking bench for float_adder_arbiter: behavioural float adder, table
// vectors, directed corner sequences and a randomized round-robin scoreboard.
module tb_float_adder_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 32;
   localparam int TO   = 64;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*DW-1:0]   req_a;
   logic [NREQ*DW-1:0]   req_b;
   logic [NREQ-1:0]      req_ready;
   logic                 resp_valid;
   logic [1:0]           resp_id;
   logic [DW-1:0]        resp_sum;
   logic                 resp_err;
   logic [DW-1:0]        add_a;
   logic [DW-1:0]        add_b;
   logic                 add_ip_ready;
   logic [DW-1:0]        add_sum;
   logic                 add_valid;
   logic                 busy;
   logic                 timeout_err;

   float_adder_arbiter #(
      .DWIDTH  (DW),
      .NREQ    (NREQ),
      .IDW     (2),
      .TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_id      (resp_id),
      .resp_sum     (resp_sum),
      .resp_err     (resp_err),
      .add_a        (add_a),
      .add_b        (add_b),
      .add_ip_ready (add_ip_ready),
      .add_sum      (add_sum),
      .add_valid    (add_valid),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit reached without finishing");
      $fatal(1);
   end

   // ---------------- float helpers (normal numbers only) ----------------
   function automatic logic [63:0] sp2dp(input logic [31:0] f);
      if (f[30:0] == 31'd0) return {f[31], 63'd0};
      return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
   endfunction

   function automatic logic [31:0] dp2sp(input logic [63:0] d);
      int         e;
      logic [23:0] m;
      logic        g, s;
      e = int'(d[62:52]) - 896;
      if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
      m = {1'b0, d[51:29]};
      g = d[28];
      s = |d[27:0];
      if (g && (s || m[0])) m = m + 24'd1;
      if (m[23]) begin
         e = e + 1;
         m = '0;
      end
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      return {d[63], 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      real r;
      r = $bitstoreal(sp2dp(a)) + $bitstoreal(sp2dp(b));
      return dp2sp($realtobits(r));
   endfunction

   function automatic logic [31:0] rand_float();
      logic [31:0] f;
      f[31]    = 1'($urandom_range(0, 1));
      f[30:23] = 8'($urandom_range(110, 140));
      f[22:0]  = 23'($urandom);
      return f;
   endfunction

   // ---------------- behavioural adder ----------------
   int m_lat;
   int m_hold_lim;
   bit m_never;
   int m_cnt;
   int m_hold;

   always @(posedge clk) begin
      if (rst) begin
         add_valid <= 1'b0;
         add_sum   <= '0;
         m_cnt     <= 0;
         m_hold    <= 0;
      end else if (add_ip_ready) begin
         m_hold <= 0;
         if (!add_valid && !m_never) begin
            if (m_cnt + 1 >= m_lat) begin
               add_valid <= 1'b1;
               add_sum   <= fadd(add_a, add_b);
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end else begin
         m_cnt <= 0;
         if (add_valid) begin
            if (m_hold >= m_hold_lim) add_valid <= 1'b0;
            else                      m_hold    <= m_hold + 1;
         end
      end
   end

   // ---------------- bookkeeping ----------------
   typedef struct {
      int          id;
      logic [31:0] sum;
      logic        err;
      int          cyc;
   } resp_t;

   typedef struct {
      int id;
      int cyc;
   } acc_t;

   typedef struct {
      int          req;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] sum;
   } vec_t;

   int    checks;
   int    errors;
   int    cyc;
   int    ipr_cnt;
   int    viol;
   bit    prev_rv;
   bit    sb_en;
   int    mptr;
   resp_t resp_q[$];
   acc_t  acc_q[$];
   resp_t exp_q[$];
   logic [31:0] pa [NREQ];
   logic [31:0] pb [NREQ];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
      pa[i] = a;
      pb[i] = b;
      req_valid[i] = 1'b1;
   endtask

   // One clock: sample at negedge, then drop accepted requests after the edge.
   task automatic step();
      logic [NREQ-1:0] acc;
      resp_t           r;
      int              gi;
      int              eg;
      @(negedge clk);
      acc = req_valid & req_ready;
      if (req_ready != '0) check("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
      if (sb_en && !busy && req_valid != '0) check("idle_grant", 64'(acc != '0), 64'd1);
      if (add_valid && req_ready != '0) viol++;
      if (acc != '0) begin
         check("ready_onehot", 64'($countones(acc)), 64'd1);
         gi = 0;
         for (int i = 0; i < NREQ; i++) if (acc[i]) gi = i;
         acc_q.push_back('{gi, cyc + 1});
         if (sb_en) begin
            eg = -1;
            for (int k = 0; k < NREQ; k++)
               if (eg < 0 && req_valid[(mptr + k) % NREQ]) eg = (mptr + k) % NREQ;
            check("sb_grant", 64'(gi), 64'(eg));
            mptr = (gi + 1) % NREQ;
            exp_q.push_back('{gi, fadd(pa[gi], pb[gi]), 1'b0, 0});
            m_lat      = $urandom_range(1, 6);
            m_hold_lim = $urandom_range(0, 3);
         end
      end
      if (add_ip_ready) ipr_cnt++;
      if (resp_valid) begin
         check("resp_gap", 64'(prev_rv), 64'd0);
         resp_q.push_back('{int'(resp_id), resp_sum, resp_err, cyc});
         if (sb_en) begin
            check("sb_pending", 64'(exp_q.size() == 0), 64'd0);
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               check("sb_id", 64'(resp_id), 64'(r.id));
               check("sb_sum", 64'(resp_sum), 64'(r.sum));
               check("sb_err", 64'(resp_err), 64'(r.err));
            end
         end
      end
      prev_rv = resp_valid;
      @(posedge clk);
      #1;
      cyc++;
      req_valid = req_valid & ~acc;
   endtask

   task automatic clear_logs();
      resp_q.delete();
      acc_q.delete();
      ipr_cnt = 0;
      viol    = 0;
   endtask

   // Bounded wait for n responses with everything idle again.
   task automatic run_until(input int n_resp, input int budget, input string name);
      for (int k = 0; k < budget; k++) begin
         if (resp_q.size() >= n_resp && !busy && req_valid == '0 && !add_valid) break;
         step();
      end
      check({name, "_resp_count"}, 64'(resp_q.size()), 64'(n_resp));
      check({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   vec_t vt[5];

   initial begin
      vt[0] = '{1, 32'h3F800000, 32'h3F800000, 1, 32'h40000000};
      vt[1] = '{3, 32'h40400000, 32'h3F000000, 2, 32'h40600000};
      vt[2] = '{1, 32'h3FC00000, 32'hBFC00000, 4, 32'h00000000};
      vt[3] = '{0, 32'h3F4CCCCD, 32'hBF000000, 3, 32'h3E99999A};
      vt[4] = '{2, 32'h3F9F7CEE, 32'h41273333, 5, 32'h413B22D1};

      checks = 0; errors = 0; cyc = 0; prev_rv = 1'b0; sb_en = 1'b0; mptr = 0;
      m_lat = 3; m_hold_lim = 0; m_never = 1'b0;
      req_valid = '0; req_a = '0; req_b = '0;
      clear_logs();
      do_reset();

      // Reset state
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ipr", 64'(add_ip_ready), 64'd0);
      check("rst_add_a", 64'(add_a), 64'd0);
      check("rst_add_b", 64'(add_b), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_id", 64'(resp_id), 64'd0);
      check("rst_resp_sum", 64'(resp_sum), 64'd0);
      check("rst_resp_err", 64'(resp_err), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);

      // Contention: all four at once, then 0 and 2
      for (int i = 0; i < NREQ; i++) raise(i, rand_float(), rand_float());
      run_until(4, 200, "cont4");
      for (int i = 0; i < 4; i++) begin
         if (i < acc_q.size())  check("cont4_grant", 64'(acc_q[i].id), 64'(i));
         if (i < resp_q.size()) check("cont4_resp_id", 64'(resp_q[i].id), 64'(i));
      end
      clear_logs();
      raise(0, rand_float(), rand_float());
      raise(2, rand_float(), rand_float());
      run_until(2, 100, "cont2");
      if (resp_q.size() == 2) begin
         check("cont2_first", 64'(resp_q[0].id), 64'd0);
         check("cont2_second", 64'(resp_q[1].id), 64'd2);
      end

      // Table vectors: single requests with known sums
      for (int v = 0; v < 5; v++) begin
         clear_logs();
         m_lat = vt[v].lat;
         m_hold_lim = 0;
         raise(vt[v].req, vt[v].a, vt[v].b);
         run_until(1, 100, "vec");
         if (resp_q.size() == 1 && acc_q.size() == 1) begin
            check("vec_id", 64'(resp_q[0].id), 64'(vt[v].req));
            check("vec_sum", 64'(resp_q[0].sum), 64'(vt[v].sum));
            check("vec_err", 64'(resp_q[0].err), 64'd0);
            check("vec_ipr_cycles", 64'(ipr_cnt), 64'(vt[v].lat + 1));
            check("vec_latency", 64'(resp_q[0].cyc - acc_q[0].cyc), 64'(vt[v].lat + 1));
         end
      end

      // Last vector served requester 2, so 3 outranks 0 now
      clear_logs();
      m_lat = 2;
      raise(0, rand_float(), rand_float());
      raise(3, rand_float(), rand_float());
      run_until(2, 100, "ptr3");
      if (resp_q.size() == 2) begin
         check("ptr3_first", 64'(resp_q[0].id), 64'd3);
         check("ptr3_second", 64'(resp_q[1].id), 64'd0);
      end

      // Watchdog: adder never answers
      clear_logs();
      m_never = 1'b1;
      raise(1, 32'h3F800000, 32'h3F800000);
      run_until(1, 200, "wd");
      if (resp_q.size() == 1 && acc_q.size() == 1) begin
         check("wd_id", 64'(resp_q[0].id), 64'd1);
         check("wd_err", 64'(resp_q[0].err), 64'd1);
         check("wd_sum", 64'(resp_q[0].sum), 64'd0);
         check("wd_latency", 64'(resp_q[0].cyc - acc_q[0].cyc), 64'(TO));
      end
      check("wd_sticky", 64'(timeout_err), 64'd1);
      clear_logs();
      m_never = 1'b0;
      m_lat = 3;
      raise(2, 32'h40400000, 32'h3F000000);
      run_until(1, 100, "wd_next");
      if (resp_q.size() == 1) begin
         check("wd_next_err", 64'(resp_q[0].err), 64'd0);
         check("wd_next_sum", 64'(resp_q[0].sum), 64'h40600000);
      end
      check("wd_sticky_after", 64'(timeout_err), 64'd1);

      // Drain hold: valid lingers 5 cycles while requester 1 waits
      clear_logs();
      m_lat = 2;
      m_hold_lim = 5;
      raise(0, 32'h3F800000, 32'h3F800000);
      for (int k = 0; k < 20 && acc_q.size() == 0; k++) step();
      raise(1, 32'h40400000, 32'h3F000000);
      run_until(2, 200, "drain");
      check("drain_ready_blocked", 64'(viol), 64'd0);
      check("drain_accepts", 64'(acc_q.size()), 64'd2);
      if (resp_q.size() == 2) begin
         check("drain_first", 64'(resp_q[0].id), 64'd0);
         check("drain_second", 64'(resp_q[1].id), 64'd1);
         check("drain_second_sum", 64'(resp_q[1].sum), 64'h40600000);
      end

      // Reset two cycles into WAIT
      clear_logs();
      m_lat = 20;
      m_hold_lim = 0;
      raise(2, rand_float(), rand_float());
      for (int k = 0; k < 20 && acc_q.size() == 0; k++) step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_ipr", 64'(add_ip_ready), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_timeout_err", 64'(timeout_err), 64'd0);
      for (int k = 0; k < 10; k++) step();
      check("mid_rst_no_resp", 64'(resp_q.size()), 64'd0);
      clear_logs();
      m_lat = 2;
      raise(1, rand_float(), rand_float());
      raise(3, rand_float(), rand_float());
      run_until(2, 100, "retry");
      if (resp_q.size() == 2) begin
         check("retry_first", 64'(resp_q[0].id), 64'd1);
         check("retry_second", 64'(resp_q[1].id), 64'd3);
      end

      // Randomized traffic against the round-robin scoreboard
      do_reset();
      clear_logs();
      exp_q.delete();
      mptr  = 0;
      sb_en = 1'b1;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] && $urandom_range(0, 7) == 0) raise(i, rand_float(), rand_float());
         step();
      end
      for (int k = 0; k < 500; k++) begin
         if (!busy && req_valid == '0 && exp_q.size() == 0 && !add_valid) break;
         step();
      end
      check("rand_drained", 64'(exp_q.size()), 64'd0);
      check("rand_no_err", 64'(timeout_err), 64'd0);
      sb_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
